// File: rtl/pipelined_subtractor_32_if.sv
// Operand/result handshake bundle for the two-stage subtractor.
// Transfer in on in_valid & in_ready, out on out_valid & out_ready; payload only meaningful with its valid.
`timescale 1ns/1ps
interface pipelined_subtractor_32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/pipelined_subtractor_32.sv
// Two-stage a - b: low half and its borrow are registered in stage 1,
// high half consumes that borrow in stage 2 and produces borrow-out and signed overflow.
`timescale 1ns/1ps
module pipelined_subtractor_32 #(
  parameter int WIDTH = 32
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_subtractor_32_if.slave bus
);
  localparam int H = WIDTH / 2;

  logic           s1_valid_q;
  logic [H-1:0]   lo_diff_q;
  logic           lo_borrow_q;
  logic [H-1:0]   a_hi_q;
  logic [H-1:0]   b_hi_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic         s1_en;
  logic         s2_en;
  logic         s1_load;
  logic [H-1:0] lo_diff_d;
  logic         lo_borrow_d;
  logic [H-1:0] hi_diff_d;
  logic         hi_borrow_d;
  logic         ovf_d;

  always_comb begin
    s2_en   = !out_valid_q || bus.out_ready;
    s1_en   = !s1_valid_q || s2_en;
    s1_load = s1_en && bus.in_valid;
    // One extra bit on each side turns the top bit of the result into the borrow.
    {lo_borrow_d, lo_diff_d} = {1'b0, bus.a[H-1:0]} - {1'b0, bus.b[H-1:0]};
    {hi_borrow_d, hi_diff_d} = {1'b0, a_hi_q} - {1'b0, b_hi_q} - {{H{1'b0}}, lo_borrow_q};
    ovf_d = (a_hi_q[H-1] ^ b_hi_q[H-1]) & (a_hi_q[H-1] ^ hi_diff_d[H-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_diff_q   <= '0;
      lo_borrow_q <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= bus.in_valid;
      end
      if (s1_load) begin
        lo_diff_q   <= lo_diff_d;
        lo_borrow_q <= lo_borrow_d;
        a_hi_q      <= bus.a[WIDTH-1:H];
        b_hi_q      <= bus.b[WIDTH-1:H];
      end
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          diff_q <= {hi_diff_d, lo_diff_q};
          bout_q <= hi_borrow_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_subtractor_32.sv
// Bench for pipelined_subtractor_32: directed corner cases plus a long random run,
// all results checked in order against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_pipelined_subtractor_32;
  localparam int W = 32;

  logic clk;
  logic rst;
  pipelined_subtractor_32_if #(.WIDTH(W)) bus ();

  pipelined_subtractor_32 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W+1:0] exp_q[$];
  logic [W+1:0] got_q[$];
  int           got_cyc[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_acc = 0;
  bit           stall = 0;
  logic [W+1:0] held;

  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    longint       sa;
    longint       sb;
    longint       sd;
    d  = av - bv;
    bo = (av < bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    sd = sa - sb;
    ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {d, bo, ov};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] got;
    got = {bus.diff, bus.bout, bus.ovf};
    if (rst) begin
      exp_q.delete();
      stall = 0;
    end else begin
      if (stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_payload", 64'(got), 64'(held));
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = got;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h expected no result", got);
        end else begin
          check("result", 64'(got), 64'(exp_q.pop_front()));
        end
        got_q.push_back(got);
        got_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int waited);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    waited       = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        exp_q.push_back(ref_sub(av, bv));
        n_acc++;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      waited++;
      if (waited > 1000) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: got no accept after %0d cycles expected accept", waited);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    bus.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    idle(2);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return {16'($urandom), 16'h0000};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  int  w;
  bit  rand_done;
  logic [W-1:0] bp_a[4];
  logic [W-1:0] bp_b[4];

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_diff", 64'(bus.diff), 64'd0);
    check("rst_bout", 64'(bus.bout), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // single op, latency
    got_q.delete();
    drive_op(32'h1233_AB71, 32'h0756_BDEF, w);
    @(negedge clk);
    check("lat_not_early", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_diff", 64'(bus.diff), 64'h0ADC_ED82);
    check("lat_bout", 64'(bus.bout), 64'd0);
    check("lat_ovf", 64'(bus.ovf), 64'd0);
    drain();

    // back-to-back streaming
    got_q.delete();
    got_cyc.delete();
    drive_op(32'h0000_0000, 32'h0000_0001, w);
    drive_op(32'h8000_0000, 32'h0000_0001, w);
    drive_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, w);
    drain();
    check("stream_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("stream0", 64'(got_q[0]), {30'd0, 32'hFFFF_FFFF, 1'b1, 1'b0});
      check("stream1", 64'(got_q[1]), {30'd0, 32'h7FFF_FFFF, 1'b0, 1'b1});
      check("stream2", 64'(got_q[2]), {30'd0, 32'h8000_0000, 1'b1, 1'b1});
      check("stream_rate01", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
      check("stream_rate12", 64'(got_cyc[2] - got_cyc[1]), 64'd1);
    end

    // backpressure
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = $urandom;
      bp_b[i] = $urandom;
    end
    n_acc = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_op(bp_a[i], bp_b[i], w);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_accepts", 64'(n_acc), 64'd2);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("bp_order", 64'(got_q[i]), 64'(ref_sub(bp_a[i], bp_b[i])));
    end

    // simultaneous retire/accept on a full pipe
    bus.out_ready = 1'b1;
    drive_op(32'h0000_1111, 32'h0000_0001, w);
    drive_op(32'h0000_2222, 32'h0000_0002, w);
    drive_op(32'd5, 32'd5, w);
    check("full_accept_wait", 64'(w), 64'd0);
    @(negedge clk);
    check("full_mid_diff", 64'(bus.diff), 64'h0000_2220);
    @(negedge clk);
    check("full_valid", 64'(bus.out_valid), 64'd1);
    check("full_diff", 64'(bus.diff), 64'd0);
    check("full_bout", 64'(bus.bout), 64'd0);
    drain();

    // reset with two ops in flight
    got_q.delete();
    bus.out_ready = 1'b0;
    drive_op(32'hDEAD_BEEF, 32'h0000_0001, w);
    drive_op(32'h1234_5678, 32'h8765_4321, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_diff", 64'(bus.diff), 64'd0);
    check("mid_rst_bout", 64'(bus.bout), 64'd0);
    check("mid_rst_ovf", 64'(bus.ovf), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    idle(6);
    check("mid_rst_no_ghost", 64'(got_q.size()), 64'd0);

    // random traffic
    got_q.delete();
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          drive_op(pick_operand(), pick_operand(), w);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    check("rand_count", 64'(got_q.size()), 64'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
